// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 4:1 mux stage: walks Sel through channels 0..3, dwells DWELL
// cycles per channel, samples the mux output and offers a 4-bit frame on valid/ready.
`timescale 1ns/1ps

module mux_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic       Continuous,
  input  logic       Mux_In,
  output logic       Sel0,
  output logic       Sel1,
  output logic       Busy,
  output logic       Frame_Valid,
  input  logic       Frame_Ready,
  output logic [3:0] Frame_Out,
  output logic [7:0] Frame_Count,
  output logic [1:0] Dbg_State
);

  // Frame handshake: Frame_Valid rises with a completed frame and holds, together
  // with Frame_Out, until an edge where Frame_Valid & Frame_Ready; Frame_Ready is
  // a don't-care whenever Frame_Valid is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t           state, state_nxt;
  logic [1:0]       ch, ch_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       shadow, shadow_nxt;
  logic [3:0]       frame_q, frame_nxt;
  logic             valid_q, valid_nxt;
  logic [7:0]       count_q, count_nxt;
  logic             dwell_done;
  logic             handshake;

  assign dwell_done = (cnt == CNT_LAST);
  assign handshake  = valid_q & Frame_Ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      ch      <= 2'd0;
      cnt     <= '0;
      shadow  <= 4'd0;
      frame_q <= 4'd0;
      valid_q <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      cnt     <= cnt_nxt;
      shadow  <= shadow_nxt;
      frame_q <= frame_nxt;
      valid_q <= valid_nxt;
      count_q <= count_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ch_nxt     = ch;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    frame_nxt  = frame_q;
    valid_nxt  = valid_q;
    count_nxt  = count_q;
    case (state)
      IDLE: begin
        ch_nxt  = 2'd0;
        cnt_nxt = '0;
        if (Start) state_nxt = SCAN;
      end
      SCAN: begin
        if (dwell_done) begin
          cnt_nxt        = '0;
          shadow_nxt[ch] = Mux_In;
          if (ch == 2'd3) begin
            // Channel 3 goes straight into the frame; shadow only holds 0..2 in time.
            frame_nxt = {Mux_In, shadow[2:0]};
            valid_nxt = 1'b1;
            ch_nxt    = 2'd0;
            state_nxt = HOLD;
          end else begin
            ch_nxt = ch + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (handshake) begin
          valid_nxt = 1'b0;
          count_nxt = count_q + 8'd1;
          ch_nxt    = 2'd0;
          cnt_nxt   = '0;
          state_nxt = Continuous ? SCAN : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        ch_nxt    = 2'd0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Select follows ch only while scanning so IDLE/HOLD always present channel 0.
  assign Sel0        = (state == SCAN) ? ch[0] : 1'b0;
  assign Sel1        = (state == SCAN) ? ch[1] : 1'b0;
  assign Busy        = (state != IDLE);
  assign Frame_Valid = valid_q;
  assign Frame_Out   = frame_q;
  assign Frame_Count = count_q;
  assign Dbg_State   = state;

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
Upstream controller for the 4-to-1 multiplexer stage. It drives Sel0/Sel1 through channels 0..3, holds each channel for a programmable dwell time, samples the mux output back, and assembles a 4-bit frame. The frame is presented on a valid/ready handshake to downstream logic. Supports single-shot scans and continuous scans.

Parameters:
DWELL, 4, clock cycles each channel is selected before sampling (legal range 1..255)
CNT_W, 8, width of the internal dwell counter (must hold DWELL-1)

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  reset; asynchronous, active-low
Start  input  1  scan request; sampled only in IDLE
Continuous  input  1  when 1, a new scan begins automatically after each frame is accepted
Mux_In  input  1  mux output fed back (MUX_Out of the mux stage)
Sel0  output  1  mux select LSB (ch[0])
Sel1  output  1  mux select MSB (ch[1])
Busy  output  1  high in SCAN or HOLD
Frame_Valid  output  1  frame available on Frame_Out
Frame_Ready  input  1  downstream accepts the frame
Frame_Out  output  4  bit i = sample of channel i
Frame_Count  output  8  count of accepted frames, wraps 255->0

Behaviour:
- Reset (async, Reset_n=0): state=IDLE, ch=0, cnt=0, Sel0=Sel1=0, Busy=0, Frame_Valid=0, Frame_Out=0, Frame_Count=0, shadow register=0. Reset takes effect immediately, including mid-scan or in HOLD. The partial frame is discarded.
- States: IDLE, SCAN, HOLD.
- IDLE: Sel=00, Busy=0. Start=1 at edge E0 -> SCAN, ch=0, cnt=0.
- SCAN: Sel1:Sel0 = ch, combinationally from the ch register. cnt increments each cycle.
  - At the edge where cnt==DWELL-1: shadow[ch] <= Mux_In and cnt <= 0.
  - If ch<3 at that edge: ch <= ch+1.
  - If ch==3 at that edge: Frame_Out <= {Mux_In, shadow[2:0]}, Frame_Valid <= 1, state <= HOLD, ch <= 0.
- Latency: samples are taken at edges E0+DWELL, E0+2·DWELL, E0+3·DWELL and E0+4·DWELL. Frame_Valid is high from E0+4·DWELL.
- HOLD: Sel=00. Frame_Out and Frame_Valid stay stable until a handshake.
  - Handshake = Frame_Valid & Frame_Ready at an edge. On the handshake: Frame_Valid <= 0 and Frame_Count <= Frame_Count+1 (mod 256).
  - Then if Continuous=1: SCAN with ch=0, cnt=0, so the next frame is valid 4·DWELL cycles later. Otherwise: IDLE.
- Frame_Ready is ignored outside HOLD. Frame_Ready held high in HOLD completes the handshake in the first HOLD cycle, so minimum HOLD occupancy is 1 cycle.
- Start is ignored in SCAN and HOLD; there is no queuing. Start and a handshake on the same edge: the handshake is honoured and Start is ignored.
- Frame_Out retains the last frame after acceptance. It changes only at frame completion.
- Continuous changing mid-scan affects only the decision made at the next HOLD exit.
- DWELL=1: one cycle per channel; samples are taken at E0+1 through E0+4.
- Busy = (state != IDLE), registered via state.

Test Plan:
- Reset then idle: Reset_n=0 for 3 cycles, release, no Start for 10 cycles -> all outputs 0, Sel=00, Busy=0.
- Single scan, DWELL=4: channel inputs I0=1,I1=0,I2=0,I3=1 drive Mux_In through a 4:1 mux model. Start pulse at E0, Frame_Ready=0.
  - Sel=00 for E0..E0+4, then 01, then 10, then 11.
  - Frame_Valid rises at E0+16 with Frame_Out=4'b1001, Busy=1.
  - Frame_Ready=1 at E0+20 -> Frame_Valid=0 at E0+21, Frame_Count=1, IDLE.
- Continuous with backpressure: Continuous=1, Frame_Ready=1 permanently, inputs 0110 -> frames of 4'b0110 every 4·DWELL+1 cycles. Frame_Count reaches 5 after 5 frames.
- Start while busy: extra Start pulses at E0+3 and in HOLD -> no restart and no change to frame timing. Exactly one frame.
- Reset mid-operation: assert Reset_n=0 asynchronously between edges at E0+9 -> outputs clear immediately, with no clock edge needed. A new Start after release gives a correct full frame.
- Wrap and DWELL=1: DWELL=1, Continuous=1, 256 accepted frames -> Frame_Count wraps to 0. Each frame is valid 4 cycles after scan start.
